// File: rtl/fifo_wr_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_wr_arb_pkg                                                          |
// | Shared types and defaults for the ALU/RF FIFO write arbiter.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fifo_wr_arb_pkg;

    localparam int c_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SEND_LO = 2'b01,
        SEND_HI = 2'b10
    } state_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_RF  = 1'b1
    } src_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb2                                                                  |
// | Two-requester round-robin grant with a registered last-served pointer.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req_alu,
    input  logic i_req_rf,
    input  logic i_upd,
    output logic o_gnt_alu,
    output logic o_gnt_rf
);
    import fifo_wr_arb_pkg::*;

    src_t r_last;

    // Pointer starts at RF so the ALU wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= SRC_RF;
        end else if (i_upd) begin
            r_last <= o_gnt_alu ? SRC_ALU : SRC_RF;
        end
    end

    always_comb begin
        o_gnt_alu = i_req_alu && (!i_req_rf || (r_last == SRC_RF));
        o_gnt_rf  = i_req_rf && !o_gnt_alu;
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_wr_arbiter                                                          |
// | Arbitrates ALU words and RF bytes into a byte-wide FIFO write port.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ALU_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
    output logic                    ALU_RDY,
    input  logic                    RF_VLD,
    input  logic [DATA_WIDTH-1:0]   RF_DATA,
    output logic                    RF_RDY,
    input  logic                    FIFO_FULL,
    output logic                    FIFO_WINC,
    output logic [DATA_WIDTH-1:0]   FIFO_WDATA,
    output logic                    BUSY
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    src_t                    r_src;
    src_t                    w_src_nxt;
    logic [2*DATA_WIDTH-1:0] r_hold;
    logic [2*DATA_WIDTH-1:0] w_hold_nxt;
    logic                    w_gnt_alu;
    logic                    w_gnt_rf;
    logic                    w_xfer;

    rr_arb2 u_rr_arb2 (
        .clk       (CLK),
        .rst       (RST),
        .i_req_alu (ALU_VLD),
        .i_req_rf  (RF_VLD),
        .i_upd     (w_xfer),
        .o_gnt_alu (w_gnt_alu),
        .o_gnt_rf  (w_gnt_rf)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_src   <= SRC_RF;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign BUSY = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_hold_nxt  = r_hold;
        ALU_RDY     = 1'b0;
        RF_RDY      = 1'b0;
        FIFO_WINC   = 1'b0;
        FIFO_WDATA  = '0;
        w_xfer      = 1'b0;
        case (r_state)
            IDLE: begin
                // Ready is masked by reset so no requester sees a handshake while held.
                ALU_RDY = w_gnt_alu && !RST;
                RF_RDY  = w_gnt_rf && !RST;
                w_xfer  = ALU_RDY || RF_RDY;
                if (ALU_RDY) begin
                    w_hold_nxt  = ALU_DATA;
                    w_src_nxt   = SRC_ALU;
                    w_state_nxt = SEND_LO;
                end else if (RF_RDY) begin
                    w_hold_nxt  = {{DATA_WIDTH{1'b0}}, RF_DATA};
                    w_src_nxt   = SRC_RF;
                    w_state_nxt = SEND_LO;
                end
            end
            SEND_LO: begin
                FIFO_WDATA = r_hold[DATA_WIDTH-1:0];
                FIFO_WINC  = !FIFO_FULL;
                if (FIFO_WINC) begin
                    w_state_nxt = (r_src == SRC_ALU) ? SEND_HI : IDLE;
                end
            end
            SEND_HI: begin
                FIFO_WDATA = r_hold[2*DATA_WIDTH-1:DATA_WIDTH];
                FIFO_WINC  = !FIFO_FULL;
                if (FIFO_WINC) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
